lomuto_partition: RTL and testbench
===================================

# lomuto_partition

Single-partition engine answering the quicksort controller's partition requests. On a `start` pulse it captures a packed array of 4-bit unsigned elements and a `[lo_ind, hi_ind]` range. It performs one Lomuto partition pass over that range, one comparison per cycle, using `a[hi_ind]` as pivot. It then returns the rearranged array, the final pivot position and a one-cycle `part_valid` strobe.

## Interface
- `ARR_WIDTH`, default 4: number of elements, legal range 2..16. Element k occupies bits `[4k+3:4k]`.
- `clock`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Synchronous, active-high.
- `array_in`: input, `ARR_WIDTH*4` bits. Array to partition, sampled only with an accepted `start`.
- `start`: input, 1 bit. Request strobe, accepted only in IDLE.
- `lo_ind`: input, 4 bits. Lower bound of range, inclusive.
- `hi_ind`: input, 4 bits. Upper bound of range, inclusive; also the pivot index.
- `pivot_ind_in`: input, 4 bits. Reserved; sampled but has no effect on behaviour.
- `array_out`: output, `ARR_WIDTH*4` bits. Working array, registered.
- `part_valid`: output, 1 bit. High for exactly one cycle when `array_out` and `pivot_ind_out` hold the result.
- `pivot_ind_out`: output, 4 bits. Final index of the pivot, registered.

## Operation
- States: IDLE, SCAN, FINAL, DONE.
- **IDLE**, `start`=1 at an edge:
  - capture `array_in` into the working array, `lo`, `hi`;
  - `pv <= array_in[hi]`;
  - `i <= lo`, `j <= lo`.
  - If `lo >= hi`, or `hi >= ARR_WIDTH`, or `lo >= ARR_WIDTH` (degenerate): array captured unchanged, `pivot_ind_out <= lo`, go to DONE.
  - Otherwise go to SCAN.
- **SCAN**, one iteration per cycle:
  - If `a[j] <= pv` (unsigned; equal elements go left): swap `a[i]` and `a[j]` (a no-op when `i == j`), then `i <= i+1`.
  - `j <= j+1` in every iteration.
  - The iteration with `j == hi-1` transitions to FINAL.
- **FINAL**: swap `a[i]` and `a[hi]`, `pivot_ind_out <= i`, go to DONE.
- **DONE**: `part_valid` = 1, go to IDLE unconditionally.
- `part_valid` is registered and equals (state == DONE).
- Post-condition:
  - elements in `[lo, p-1]` are <= `pv`;
  - `a[p]` = `pv`;
  - elements in `[p+1, hi]` are > `pv`;
  - elements outside `[lo, hi]` are untouched.
- `start` in SCAN, FINAL or DONE is ignored: no queueing, no effect on the current pass.
- `array_out` and `pivot_ind_out` hold their value in IDLE until the next accepted `start`. During SCAN and FINAL `array_out` shows intermediate contents, which are meaningful only while `part_valid` = 1.
- Index arithmetic is 4-bit. With `hi <= ARR_WIDTH-1 <= 15`, `i` and `j` never wrap.

## Timing
- Reset values: state IDLE, `array_out` = 0, `pivot_ind_out` = 0, `part_valid` = 0; `i`, `j`, `lo`, `hi`, `pv` = 0.
- Reset in any state aborts the pass with no `part_valid` pulse. The next `start` after reset is accepted normally.
- Latency: with `start` high in cycle 0 and N = `hi-lo` (non-degenerate case):
  - SCAN occupies cycles 1..N;
  - FINAL occupies cycle N+1;
  - `part_valid` is high in cycle N+2.
- Degenerate case: `part_valid` is high in cycle 1.
- Earliest accepted re-start is the cycle after `part_valid`, i.e. the first IDLE cycle. Back-to-back throughput is therefore N+3 cycles per pass.
- `part_valid` never stays high for two consecutive cycles.

## Test plan
- **Basic pass.** Stimulus: `ARR_WIDTH`=4, `array_in`=16'h2413 (e0..e3 = 3,1,4,2), `lo`=0, `hi`=3, start in cycle 0. Required: `part_valid` only in cycle 5, `array_out`=16'h3421, `pivot_ind_out`=1.
- **Sub-range.** Stimulus: same array, `lo`=1, `hi`=3. Required: `part_valid` in cycle 4, `array_out`=16'h4213 (element e0=3 untouched), `pivot_ind_out`=2.
- **Degenerate ranges.** Stimulus: `lo`=2, `hi`=2, then `lo`=3, `hi`=1, then `hi`=5 with `ARR_WIDTH`=4. Required: each gives `part_valid` in cycle 1, `array_out` = `array_in`, `pivot_ind_out` = `lo`.
- **Duplicates and sorted input.** Stimulus: 16'h5555 with `lo`=0, `hi`=3. Required: `array_out`=16'h5555, `pivot_ind_out`=3. Stimulus: 16'h4321 (already sorted). Required: unchanged, `pivot_ind_out`=3.
- **Protocol robustness.** Stimulus: `start` re-asserted with a different array every SCAN cycle. Required: result identical to the basic pass. Stimulus: reset asserted in cycle 2 of a pass. Required: all outputs 0 next cycle and no `part_valid`. A fresh start then gives the basic-pass result.
- **Randomised.** Stimulus: `ARR_WIDTH`=8, 1000 random arrays and ranges. Required: matches a Lomuto reference model bit-exactly; `part_valid` latency equals `hi-lo+2` (1 if degenerate); post-condition holds on every pass.

Source files
------------

// File: rtl/lomuto_partition.sv
// lomuto_partition
//   Single-pass Lomuto partition engine for the quicksort controller.
//   A start pulse in IDLE captures a packed array of 4-bit unsigned elements
//   and an inclusive range [lo_ind, hi_ind]. The engine then partitions that
//   range around a[hi_ind], doing one comparison per cycle. It returns the
//   rearranged array, the final pivot index and a one-cycle part_valid strobe.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   array_in       ARR_WIDTH x 4-bit elements, element k at [4k+3:4k]
//   start          request strobe, honoured only in IDLE
//   lo_ind/hi_ind  inclusive range bounds; hi_ind is also the pivot index
//   pivot_ind_in   reserved; has no effect
//   array_out      working array (registered)
//   part_valid     high for one cycle when array_out/pivot_ind_out are final
//   pivot_ind_out  final pivot position (registered)

module lomuto_partition #(
    parameter int ARR_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ARR_WIDTH*4-1:0] array_in,
    input  logic                   start,
    input  logic [3:0]             lo_ind,
    input  logic [3:0]             hi_ind,
    input  logic [3:0]             pivot_ind_in,
    output logic [ARR_WIDTH*4-1:0] array_out,
    output logic                   part_valid,
    output logic [3:0]             pivot_ind_out
);

    typedef enum logic [1:0] {IDLE, SCAN, FINAL, DONE} state_t;

    state_t                      state_q, state_d;
    logic [ARR_WIDTH-1:0][3:0]   arr_q, arr_d, arr_in_w;
    logic [3:0]                  lo_q, lo_d, hi_q, hi_d, pv_q, pv_d;
    logic [3:0]                  i_q, i_d, j_q, j_d, pidx_q, pidx_d;
    logic [3:0]                  a_i, a_j, a_hi, in_hi;
    logic                        degen;

    // lo is kept only as captured state; the reserved pivot input has no effect.
    logic unused_sigs;
    assign unused_sigs = ^{pivot_ind_in, lo_q};

    assign arr_in_w = array_in;

    // Element read muxes, built as compare-and-select loops so the 4-bit
    // indices work for any ARR_WIDTH without out-of-range selects.
    always_comb begin
        a_i   = '0;
        a_j   = '0;
        a_hi  = '0;
        in_hi = '0;
        for (int k = 0; k < ARR_WIDTH; k++) begin
            if (4'(k) == i_q)    a_i   = arr_q[k];
            if (4'(k) == j_q)    a_j   = arr_q[k];
            if (4'(k) == hi_q)   a_hi  = arr_q[k];
            if (4'(k) == hi_ind) in_hi = arr_in_w[k];
        end
    end

    // The range is degenerate when it is empty or falls outside the array.
    // Indices are widened by one bit so the test also works for ARR_WIDTH = 16.
    assign degen = (lo_ind >= hi_ind) ||
                   ({1'b0, hi_ind} >= 5'(ARR_WIDTH)) ||
                   ({1'b0, lo_ind} >= 5'(ARR_WIDTH));

    always_comb begin
        state_d = state_q;
        arr_d   = arr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        pv_d    = pv_q;
        i_d     = i_q;
        j_d     = j_q;
        pidx_d  = pidx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    arr_d = arr_in_w;
                    lo_d  = lo_ind;
                    hi_d  = hi_ind;
                    pv_d  = in_hi;
                    i_d   = lo_ind;
                    j_d   = lo_ind;
                    if (degen) begin
                        pidx_d  = lo_ind;
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                // Equal elements go to the left side. When i == j both
                // writes target the same slot with the same value.
                if (a_j <= pv_q) begin
                    for (int k = 0; k < ARR_WIDTH; k++) begin
                        if (4'(k) == j_q) arr_d[k] = a_i;
                        if (4'(k) == i_q) arr_d[k] = a_j;
                    end
                    i_d = i_q + 4'd1;
                end
                j_d = j_q + 4'd1;
                if (j_q == hi_q - 4'd1) state_d = FINAL;
            end
            FINAL: begin
                for (int k = 0; k < ARR_WIDTH; k++) begin
                    if (4'(k) == hi_q) arr_d[k] = a_i;
                    if (4'(k) == i_q)  arr_d[k] = a_hi;
                end
                pidx_d  = i_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            arr_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            pv_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            pidx_q  <= '0;
        end else begin
            state_q <= state_d;
            arr_q   <= arr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            pv_q    <= pv_d;
            i_q     <= i_d;
            j_q     <= j_d;
            pidx_q  <= pidx_d;
        end
    end

    assign array_out     = arr_q;
    assign pivot_ind_out = pidx_q;
    assign part_valid    = (state_q == DONE);

endmodule

// File: tb/tb_lomuto_partition.sv
module tb_lomuto_partition;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Instance 0: ARR_WIDTH = 4, instance 1: ARR_WIDTH = 8
    logic        s4_start, o4_vld;
    logic [15:0] s4_arr, o4_arr;
    logic [3:0]  s4_lo, s4_hi, s4_pin, o4_piv;
    logic        s8_start, o8_vld;
    logic [31:0] s8_arr, o8_arr;
    logic [3:0]  s8_lo, s8_hi, s8_pin, o8_piv;

    lomuto_partition #(.ARR_WIDTH(4)) u4 (
        .clock(clock), .reset(reset), .array_in(s4_arr), .start(s4_start),
        .lo_ind(s4_lo), .hi_ind(s4_hi), .pivot_ind_in(s4_pin),
        .array_out(o4_arr), .part_valid(o4_vld), .pivot_ind_out(o4_piv));

    lomuto_partition #(.ARR_WIDTH(8)) u8 (
        .clock(clock), .reset(reset), .array_in(s8_arr), .start(s8_start),
        .lo_ind(s8_lo), .hi_ind(s8_hi), .pivot_ind_in(s8_pin),
        .array_out(o8_arr), .part_valid(o8_vld), .pivot_ind_out(o8_piv));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          active;
        int          cyc;
        int          lat;
        int          lo;
        int          hi;
        int          n;
        logic [63:0] ain;
        logic [63:0] arr;
        logic [3:0]  piv;
    } exp_t;
    exp_t ex[2];

    logic [63:0] aout[2];
    logic        vld[2];
    logic [3:0]  pout[2];
    assign aout[0] = 64'(o4_arr);
    assign aout[1] = 64'(o8_arr);
    assign vld[0]  = o4_vld;
    assign vld[1]  = o8_vld;
    assign pout[0] = o4_piv;
    assign pout[1] = o8_piv;

    function automatic logic [3:0] el(logic [63:0] a, int k);
        return a[k*4 +: 4];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: textbook Lomuto partition on an element array.
    function automatic void model(input logic [63:0] a, input int n, input int lo,
                                  input int hi, output logic [63:0] r,
                                  output int p, output int lat);
        logic [3:0] e[16];
        logic [3:0] pv, t;
        int i;
        for (int k = 0; k < 16; k++) e[k] = el(a, k);
        if (lo >= hi || hi >= n || lo >= n) begin
            r = a; p = lo; lat = 1;
        end else begin
            pv = e[hi];
            i  = lo;
            for (int j = lo; j < hi; j++)
                if (e[j] <= pv) begin
                    t = e[i]; e[i] = e[j]; e[j] = t; i++;
                end
            t = e[i]; e[i] = e[hi]; e[hi] = t;
            p   = i;
            lat = hi - lo + 2;
            r   = '0;
            for (int k = 0; k < n; k++) r[k*4 +: 4] = e[k];
        end
    endfunction

    function automatic bit post_ok(logic [63:0] r, logic [63:0] ain, int n,
                                   int lo, int hi, int p, bit degen);
        logic [3:0] pv;
        if (degen) return r == ain;
        pv = el(ain, hi);
        for (int k = 0; k < n; k++) begin
            if (k < lo || k > hi) begin
                if (el(r, k) != el(ain, k)) return 0;
            end else if (k < p) begin
                if (el(r, k) > pv) return 0;
            end else if (k == p) begin
                if (el(r, k) != pv) return 0;
            end else begin
                if (el(r, k) <= pv) return 0;
            end
        end
        return 1;
    endfunction

    // Cycle-by-cycle compare: part_valid only at the model's latency, result
    // and post-condition at that cycle, result still held the cycle after.
    always @(posedge clock) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                if (ex[d].active) begin
                    ex[d].cyc++;
                    if (ex[d].cyc < ex[d].lat) begin
                        check("vld_early", 64'(vld[d]), 64'd0);
                    end else if (ex[d].cyc == ex[d].lat) begin
                        check("vld_latency", 64'(vld[d]), 64'd1);
                        check("array_out", aout[d], ex[d].arr);
                        check("pivot_ind_out", 64'(pout[d]), 64'(ex[d].piv));
                        check("postcond", 64'(post_ok(aout[d], ex[d].ain, ex[d].n,
                              ex[d].lo, ex[d].hi, int'(pout[d]), ex[d].lat == 1)), 64'd1);
                    end else begin
                        check("vld_twice", 64'(vld[d]), 64'd0);
                        check("array_hold", aout[d], ex[d].arr);
                        ex[d].active = 0;
                    end
                end else begin
                    check("vld_idle", 64'(vld[d]), 64'd0);
                end
            end
        end
    end

    // Called at a negedge. Holds start for 1+extra cycles; the extra cycles
    // carry unrelated arrays/ranges that must be ignored.
    task automatic launch(int d, logic [63:0] a, int lo, int hi, int extra);
        int n = (d != 0) ? 8 : 4;
        logic [63:0] am, r;
        int p, lat;
        am = '0;
        for (int k = 0; k < n; k++) am[k*4 +: 4] = el(a, k);
        model(am, n, lo, hi, r, p, lat);
        ex[d] = '{1'b1, 0, lat, lo, hi, n, am, r, 4'(p)};
        if (d == 0) begin
            s4_arr = am[15:0]; s4_lo = 4'(lo); s4_hi = 4'(hi);
            s4_pin = 4'($urandom); s4_start = 1'b1;
        end else begin
            s8_arr = am[31:0]; s8_lo = 4'(lo); s8_hi = 4'(hi);
            s8_pin = 4'($urandom); s8_start = 1'b1;
        end
        @(negedge clock);
        for (int c = 0; c < extra; c++) begin
            if (d == 0) begin
                s4_arr = 16'($urandom); s4_lo = 4'($urandom); s4_hi = 4'($urandom);
            end else begin
                s8_arr = $urandom; s8_lo = 4'($urandom); s8_hi = 4'($urandom);
            end
            @(negedge clock);
        end
        s4_start = 1'b0;
        s8_start = 1'b0;
    endtask

    task automatic wait_done(int d);
        for (int c = 0; c < 40 && ex[d].active; c++) @(negedge clock);
        if (ex[d].active) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: part_valid never came on instance %0d", d);
            ex[d].active = 0;
        end
    endtask

    task automatic run(int d, logic [63:0] a, int lo, int hi);
        launch(d, a, lo, hi, 0);
        wait_done(d);
    endtask

    initial begin
        logic [63:0] r;
        int p, lat;
        ex[0] = '{1'b0, 0, 0, 0, 0, 4, '0, '0, '0};
        ex[1] = '{1'b0, 0, 0, 0, 0, 8, '0, '0, '0};
        reset = 1'b1;
        s4_start = 0; s4_arr = 0; s4_lo = 0; s4_hi = 0; s4_pin = 0;
        s8_start = 0; s8_arr = 0; s8_lo = 0; s8_hi = 0; s8_pin = 0;

        // Pin the model to hand-computed values.
        model(64'h2413, 4, 0, 3, r, p, lat);
        check("model_basic_arr", r, 64'h3421);
        check("model_basic_piv", 64'(p), 64'd1);
        check("model_basic_lat", 64'(lat), 64'd5);
        model(64'h2413, 4, 1, 3, r, p, lat);
        check("model_sub_arr", r, 64'h4213);
        check("model_sub_piv", 64'(p), 64'd2);

        repeat (3) @(negedge clock);
        check("rst_arr4", 64'(o4_arr), 64'd0);
        check("rst_piv4", 64'(o4_piv), 64'd0);
        check("rst_vld4", 64'(o4_vld), 64'd0);
        check("rst_arr8", 64'(o8_arr), 64'd0);
        check("rst_vld8", 64'(o8_vld), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Basic pass and sub-range
        run(0, 64'h2413, 0, 3);
        check("basic_arr", 64'(o4_arr), 64'h3421);
        check("basic_piv", 64'(o4_piv), 64'd1);
        run(0, 64'h2413, 1, 3);
        check("sub_arr", 64'(o4_arr), 64'h4213);
        check("sub_piv", 64'(o4_piv), 64'd2);

        // Degenerate ranges
        run(0, 64'h2413, 2, 2);
        check("degen_eq_arr", 64'(o4_arr), 64'h2413);
        check("degen_eq_piv", 64'(o4_piv), 64'd2);
        run(0, 64'h9c07, 3, 1);
        check("degen_inv_arr", 64'(o4_arr), 64'h9c07);
        check("degen_inv_piv", 64'(o4_piv), 64'd3);
        run(0, 64'h1f2e, 1, 5);
        check("degen_oob_arr", 64'(o4_arr), 64'h1f2e);
        check("degen_oob_piv", 64'(o4_piv), 64'd1);

        // Duplicates and sorted input
        run(0, 64'h5555, 0, 3);
        check("dup_arr", 64'(o4_arr), 64'h5555);
        check("dup_piv", 64'(o4_piv), 64'd3);
        run(0, 64'h4321, 0, 3);
        check("sorted_arr", 64'(o4_arr), 64'h4321);
        check("sorted_piv", 64'(o4_piv), 64'd3);

        // start held through SCAN, FINAL and DONE with other data
        launch(0, 64'h2413, 0, 3, 5);
        wait_done(0);
        check("restart_arr", 64'(o4_arr), 64'h3421);
        check("restart_piv", 64'(o4_piv), 64'd1);

        // Reset in cycle 2 of a pass
        launch(0, 64'h2413, 0, 3, 0);
        @(negedge clock);
        reset = 1'b1;
        ex[0].active = 0;
        @(negedge clock);
        reset = 1'b0;
        check("abort_arr", 64'(o4_arr), 64'd0);
        check("abort_piv", 64'(o4_piv), 64'd0);
        check("abort_vld", 64'(o4_vld), 64'd0);
        repeat (3) @(negedge clock);
        run(0, 64'h2413, 0, 3);
        check("after_rst_arr", 64'(o4_arr), 64'h3421);
        check("after_rst_piv", 64'(o4_piv), 64'd1);

        // Randomised passes on the 8-wide instance, ranges include degenerate
        for (int t = 0; t < 1000; t++)
            run(1, 64'($urandom), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
